// File: rtl/sd4_pp_gen_pipe.sv
// Multi-lane SD4 partial-product generator: a weight-stationary bank feeding a
// 2-stage valid/ready pipeline that also summarises max exponent and live lanes.
module sd4_pp_gen_pipe #(
  parameter int LANES = 4,
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int WEXP_W = 3,
  parameter logic [WEXP_W:0] WZ_MASK = 4'b0111,
  localparam int IMG_W = 1 + EXP_W + MAN_W,
  localparam int WGT_W = WEXP_W + 1,
  localparam int PP_W = MAN_W + 2,
  localparam int OEXP_W = ((EXP_W > WEXP_W) ? EXP_W : WEXP_W) + 1,
  localparam int CNT_W = $clog2(LANES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_load,
  input  logic [LANES*WGT_W-1:0]    w_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*IMG_W-1:0]    in_image,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*PP_W-1:0]     out_pp,
  output logic [LANES*OEXP_W-1:0]   out_exp,
  output logic [LANES-1:0]          out_zero,
  output logic [OEXP_W-1:0]         out_max_exp,
  output logic [CNT_W-1:0]          out_nz_cnt
);

  // Handshake: a stage advances when it is empty or the stage after it advances.
  // Upstream sees in_ready = s1_adv; a vector moves on valid & ready at the edge.
  logic [LANES*WGT_W-1:0]  w_bank;
  logic                    s1_valid, s2_valid;
  logic                    s1_adv, s2_adv, accept;

  logic [LANES*PP_W-1:0]   s1_pp, s1_pp_d, s2_pp;
  logic [LANES*OEXP_W-1:0] s1_exp, s1_exp_d, s2_exp;
  logic [LANES-1:0]        s1_zero, s1_zero_d, s2_zero;
  logic [OEXP_W-1:0]       s2_max, s2_max_d;
  logic [CNT_W-1:0]        s2_cnt, s2_cnt_d;

  assign s2_adv   = ~s2_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid & in_ready;

  always_comb begin
    logic [IMG_W-1:0] img;
    logic [WGT_W-1:0] wgt;
    logic             lz;
    s1_pp_d   = '0;
    s1_exp_d  = '0;
    s1_zero_d = '0;
    img       = '0;
    wgt       = '0;
    lz        = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      img = in_image[i*IMG_W +: IMG_W];
      wgt = w_bank[i*WGT_W +: WGT_W];
      // exp and man together are the low IMG_W-1 bits; the image sign is ignored
      lz = (img[IMG_W-2:0] == '0) || ((wgt & WZ_MASK) == WZ_MASK);
      s1_zero_d[i] = lz;
      if (!lz) begin
        s1_pp_d[i*PP_W +: PP_W]      = {img[IMG_W-1] ^ wgt[0], 1'b1, img[MAN_W-1:0]};
        s1_exp_d[i*OEXP_W +: OEXP_W] = OEXP_W'(img[MAN_W +: EXP_W]) + OEXP_W'(wgt[WGT_W-1:1]);
      end
    end
  end

  always_comb begin
    logic [OEXP_W-1:0] lexp;
    s2_max_d = '0;
    s2_cnt_d = '0;
    lexp     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!s1_zero[i]) begin
        lexp = s1_exp[i*OEXP_W +: OEXP_W];
        if (lexp > s2_max_d) s2_max_d = lexp;
        s2_cnt_d = s2_cnt_d + CNT_W'(1);
      end
    end
  end

  // An image accepted on a load edge still sees the old bank contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_bank <= '0;
    end else if (w_load) begin
      w_bank <= w_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pp    <= '0;
      s1_exp   <= '0;
      s1_zero  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_pp    <= s1_pp_d;
      s1_exp   <= s1_exp_d;
      s1_zero  <= s1_zero_d;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 data only changes when a real vector arrives, so outputs hold through bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_pp    <= '0;
      s2_exp   <= '0;
      s2_zero  <= '0;
      s2_max   <= '0;
      s2_cnt   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_pp   <= s1_pp;
        s2_exp  <= s1_exp;
        s2_zero <= s1_zero;
        s2_max  <= s2_max_d;
        s2_cnt  <= s2_cnt_d;
      end
    end
  end

  assign out_valid   = s2_valid;
  assign out_pp      = s2_pp;
  assign out_exp     = s2_exp;
  assign out_zero    = s2_zero;
  assign out_max_exp = s2_max;
  assign out_nz_cnt  = s2_cnt;

endmodule

// File: tb/tb_sd4_pp_gen_pipe.sv
// Bench for sd4_pp_gen_pipe: directed scenarios plus random traffic, scored
// against an integer-arithmetic model of each lane and the vector summary.
module tb_sd4_pp_gen_pipe;

  localparam int VW = 52;  // {pp[19:0], exp[19:0], zero[3:0], max[4:0], cnt[2:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic        w_load;
  logic [15:0] w_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_image;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_pp;
  logic [19:0] out_exp;
  logic [3:0]  out_zero;
  logic [4:0]  out_max_exp;
  logic [2:0]  out_nz_cnt;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  logic [15:0]   model_w = '0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] act_q[$];

  sd4_pp_gen_pipe dut (
    .clk(clk), .rst(rst), .w_load(w_load), .w_in(w_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_image(in_image),
    .out_valid(out_valid), .out_ready(out_ready), .out_pp(out_pp),
    .out_exp(out_exp), .out_zero(out_zero), .out_max_exp(out_max_exp),
    .out_nz_cnt(out_nz_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Reference: lane value decoded with integer arithmetic.
  function automatic logic [VW-1:0] model(input logic [31:0] img_v, input logic [15:0] w_v);
    logic [19:0] pp_v, ex_v;
    logic [3:0]  z_v;
    int mx, cnt;
    pp_v = '0; ex_v = '0; z_v = '0; mx = 0; cnt = 0;
    for (int i = 0; i < 4; i++) begin
      int im, w, man, e, s, ws, we, p, x;
      im = int'(img_v[i*8 +: 8]);
      w  = int'(w_v[i*4 +: 4]);
      man = im % 8; e = (im / 8) % 16; s = im / 128;
      ws = w % 2; we = w / 2;
      if ((e == 0 && man == 0) || (w % 8) == 7) begin
        z_v[i] = 1'b1;
      end else begin
        p = ((s ^ ws) * 16) + 8 + man;
        x = e + we;
        pp_v[i*5 +: 5] = p[4:0];
        ex_v[i*5 +: 5] = x[4:0];
        if (x > mx) mx = x;
        cnt++;
      end
    end
    return {pp_v, ex_v, z_v, mx[4:0], cnt[2:0]};
  endfunction

  function automatic logic [31:0] rand_img();
    logic [31:0] v;
    logic [7:0]  b;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) b[6:0] = '0;
      v[i*8 +: 8] = b;
    end
    return v;
  endfunction

  // driver: inputs already set just after a negedge; records traffic, runs one cycle
  task automatic tick();
    #1;
    if (out_valid && out_ready)
      act_q.push_back({out_pp, out_exp, out_zero, out_max_exp, out_nz_cnt});
    if (in_valid && in_ready) begin
      exp_q.push_back(model(in_image, model_w));
      acc_cnt++;
    end
    if (w_load) model_w = w_in;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid = 1'b0; w_load = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 30 && act_q.size() < exp_q.size(); c++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; w_load = 1'b1; w_in = 16'($urandom_range(0, 65535));
    in_valid = 1'b1; in_image = $urandom; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    checks++; if (out_pp !== '0) begin errors++; $display("FAIL rst_pp got=%h want=0", out_pp); end
    checks++; if (out_exp !== '0) begin errors++; $display("FAIL rst_exp got=%h want=0", out_exp); end
    checks++; if (out_zero !== '0) begin errors++; $display("FAIL rst_zero got=%b want=0", out_zero); end
    checks++; if (out_max_exp !== '0) begin errors++; $display("FAIL rst_max got=%0d want=0", out_max_exp); end
    checks++; if (out_nz_cnt !== '0) begin errors++; $display("FAIL rst_cnt got=%0d want=0", out_nz_cnt); end
    @(negedge clk);
    rst = 1'b0; w_load = 1'b0; in_valid = 1'b0; model_w = '0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    // weight bank must still be zero: a load during reset is ignored
    in_image = {4{8'b0_0101_011}}; in_valid = 1'b1; tick();
    drain();
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      checks++; if (act_q[0] !== exp_q[0]) begin errors++; $display("FAIL rst_vec got=%h want=%h", act_q[0], exp_q[0]); end
      void'(act_q.pop_front()); void'(exp_q.pop_front());
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_basic();
    w_in = {4{4'b010_1}}; w_load = 1'b1; in_valid = 1'b0; out_ready = 1'b1; tick();
    w_load = 1'b0; in_image = {4{8'b0_0101_011}}; in_valid = 1'b1; tick();
    in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1 got=%b want=0", out_valid); end
    tick(); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_lat2 got=%b want=1", out_valid); end
    checks++; if (out_pp !== {4{5'h1B}}) begin errors++; $display("FAIL basic_pp got=%h want=%h", out_pp, {4{5'h1B}}); end
    checks++; if (out_exp !== {4{5'd7}}) begin errors++; $display("FAIL basic_exp got=%h want=%h", out_exp, {4{5'd7}}); end
    checks++; if (out_zero !== 4'b0000) begin errors++; $display("FAIL basic_zero got=%b want=0000", out_zero); end
    checks++; if (out_max_exp !== 5'd7) begin errors++; $display("FAIL basic_max got=%0d want=7", out_max_exp); end
    checks++; if (out_nz_cnt !== 3'd4) begin errors++; $display("FAIL basic_cnt got=%0d want=4", out_nz_cnt); end
    drain();
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      checks++; if (act_q[0] !== exp_q[0]) begin errors++; $display("FAIL basic_vec got=%h want=%h", act_q[0], exp_q[0]); end
      void'(act_q.pop_front()); void'(exp_q.pop_front());
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_zeros();
    w_in = {4'b0000, 4'b0000, 4'b0000, 4'b0111}; w_load = 1'b1; in_valid = 1'b0; tick();
    w_load = 1'b0;
    in_image = {8'b0_1001_010, 8'b1_0011_101, 8'b1_0000_000, 8'b0_0110_001};
    in_valid = 1'b1; tick(); in_valid = 1'b0; tick(); #1;
    checks++; if (out_zero !== 4'b0011) begin errors++; $display("FAIL zero_flags got=%b want=0011", out_zero); end
    checks++; if (out_pp[9:0] !== 10'd0) begin errors++; $display("FAIL zero_pp01 got=%h want=0", out_pp[9:0]); end
    checks++; if (out_exp[9:0] !== 10'd0) begin errors++; $display("FAIL zero_exp01 got=%h want=0", out_exp[9:0]); end
    checks++; if (out_pp[14:10] !== 5'b11101) begin errors++; $display("FAIL zero_pp2 got=%b want=11101", out_pp[14:10]); end
    checks++; if (out_max_exp !== 5'd9) begin errors++; $display("FAIL zero_max got=%0d want=9", out_max_exp); end
    checks++; if (out_nz_cnt !== 3'd2) begin errors++; $display("FAIL zero_cnt got=%0d want=2", out_nz_cnt); end
    in_image = {8'b1_0000_000, 8'b0_0000_000, 8'b1_0000_000, 8'b0_0000_000};
    in_valid = 1'b1; tick(); in_valid = 1'b0; tick(); #1;
    checks++; if (out_zero !== 4'b1111) begin errors++; $display("FAIL allz_flags got=%b want=1111", out_zero); end
    checks++; if (out_max_exp !== 5'd0) begin errors++; $display("FAIL allz_max got=%0d want=0", out_max_exp); end
    checks++; if (out_nz_cnt !== 3'd0) begin errors++; $display("FAIL allz_cnt got=%0d want=0", out_nz_cnt); end
    drain();
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL zero_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      checks++; if (act_q[0] !== exp_q[0]) begin errors++; $display("FAIL zero_vec got=%h want=%h", act_q[0], exp_q[0]); end
      void'(act_q.pop_front()); void'(exp_q.pop_front());
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] snap;
    int start;
    snap = '0;
    w_in = 16'($urandom_range(0, 65535)); w_load = 1'b1; in_valid = 1'b0; tick();
    w_load = 1'b0; out_ready = 1'b0; in_valid = 1'b1; start = acc_cnt;
    for (int c = 0; c < 4; c++) begin
      in_image = rand_img();
      #1;
      if (c == 2) snap = {out_pp, out_exp, out_zero, out_max_exp, out_nz_cnt};
      if (c >= 2) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c=%0d got=%b want=0", c, in_ready); end
      end
      if (c == 3) begin
        checks++;
        if ({out_pp, out_exp, out_zero, out_max_exp, out_nz_cnt} !== snap) begin
          errors++; $display("FAIL bp_stable got=%h want=%h", {out_pp, out_exp, out_zero, out_max_exp, out_nz_cnt}, snap);
        end
      end
      tick();
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_shift_accept got=%b want=1", in_ready); end
    for (int c = 0; c < 40 && (acc_cnt - start) < 6; c++) begin
      in_image = rand_img(); tick();
    end
    checks++; if (acc_cnt - start != 6) begin errors++; $display("FAIL bp_accepts got=%0d want=6", acc_cnt - start); end
    drain();
    checks++; if (act_q.size() != 6 || exp_q.size() != 6) begin errors++; $display("FAIL bp_count got=%0d want=6", act_q.size()); end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      checks++; if (act_q[0] !== exp_q[0]) begin errors++; $display("FAIL bp_vec got=%h want=%h", act_q[0], exp_q[0]); end
      void'(act_q.pop_front()); void'(exp_q.pop_front());
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_weight_swap();
    w_in = {4{4'b001_0}}; w_load = 1'b1; in_valid = 1'b0; out_ready = 1'b1; tick();
    w_in = {4{4'b010_0}}; in_image = {4{8'b0_0011_000}}; in_valid = 1'b1; tick();
    w_load = 1'b0; tick();
    in_valid = 1'b0; #1;
    checks++; if (out_max_exp !== 5'd4) begin errors++; $display("FAIL swap_a_max got=%0d want=4", out_max_exp); end
    checks++; if (out_exp !== {4{5'd4}}) begin errors++; $display("FAIL swap_a_exp got=%h want=%h", out_exp, {4{5'd4}}); end
    tick(); #1;
    checks++; if (out_max_exp !== 5'd5) begin errors++; $display("FAIL swap_b_max got=%0d want=5", out_max_exp); end
    drain();
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL swap_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      checks++; if (act_q[0] !== exp_q[0]) begin errors++; $display("FAIL swap_vec got=%h want=%h", act_q[0], exp_q[0]); end
      void'(act_q.pop_front()); void'(exp_q.pop_front());
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      w_load    = ($urandom_range(0, 9) == 0);
      w_in      = 16'($urandom_range(0, 65535));
      in_image  = rand_img();
      tick();
    end
    drain();
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      checks++; if (act_q[0] !== exp_q[0]) begin errors++; $display("FAIL rand_vec got=%h want=%h", act_q[0], exp_q[0]); end
      void'(act_q.pop_front()); void'(exp_q.pop_front());
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0; w_load = 1'b0; in_valid = 1'b1;
    in_image = rand_img(); tick();
    in_image = rand_img(); tick();
    in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_full got=%b want=1", out_valid); end
    rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async got=%b want=0", out_valid); end
    checks++; if (out_pp !== '0) begin errors++; $display("FAIL mid_pp got=%h want=0", out_pp); end
    exp_q.delete(); act_q.delete(); model_w = '0;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    in_image = rand_img(); in_valid = 1'b1; tick();
    drain();
    checks++; if (act_q.size() != 1 || exp_q.size() != 1) begin errors++; $display("FAIL mid_count got=%0d want=1", act_q.size()); end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      checks++; if (act_q[0] !== exp_q[0]) begin errors++; $display("FAIL mid_vec got=%h want=%h", act_q[0], exp_q[0]); end
      void'(act_q.pop_front()); void'(exp_q.pop_front());
    end
    act_q.delete(); exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; w_load = 1'b0; w_in = '0; in_valid = 1'b0; in_image = '0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_zeros();
    test_backpressure();
    test_weight_swap();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
